// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-deep id_* pipeline register, redirect/halt control.
// Instruction memory is read combinationally from imem_addr in the same cycle.
module fetch_stage #(
  parameter int unsigned                IMEM_ADDR_WIDTH = 32,
  parameter int unsigned                IMEM_DATA_WIDTH = 32,
  parameter logic [IMEM_ADDR_WIDTH-1:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [IMEM_DATA_WIDTH-1:0] imem_data,
  input  logic                       redirect_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
  input  logic                       halt,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [IMEM_DATA_WIDTH-1:0] id_instr,
  output logic [IMEM_ADDR_WIDTH-1:0] id_pc,
  output logic [IMEM_ADDR_WIDTH-1:0] id_pc_plus4,
  output logic                       misalign_err,
  output logic [31:0]                fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  state_e                     state_q, state_d;
  logic [IMEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [IMEM_ADDR_WIDTH-1:0] pc_plus4;
  logic                       id_valid_q, id_valid_d;
  logic [IMEM_DATA_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [IMEM_ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [IMEM_ADDR_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic                       misalign_q, misalign_d;
  logic [31:0]                fetch_count_q, fetch_count_d;

  assign pc_plus4 = pc_q + IMEM_ADDR_WIDTH'(4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    misalign_d    = 1'b0;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      // Flush wins over everything, including a held (stalled) instruction.
      pc_d       = {redirect_pc[IMEM_ADDR_WIDTH-1:2], 2'b00};
      id_valid_d = 1'b0;
      misalign_d = |redirect_pc[1:0];
      state_d    = StRun;
    end else begin
      case (state_q)
        StBoot: begin
          state_d = StRun;
          if (id_ready) id_valid_d = 1'b0;
        end
        StRun: begin
          if (halt) begin
            state_d = StHalted;
            if (id_ready) id_valid_d = 1'b0;
          end else if (!id_valid_q || id_ready) begin
            id_instr_d    = imem_data;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
        StHalted: begin
          if (id_ready) id_valid_d = 1'b0;
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus4  = id_pc_plus4_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, and randomized run vs a reference model.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect_valid, halt, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_data, id_instr, id_pc, id_pc_plus4, fetch_count;
  logic        id_valid, misalign_err;

  // Memory word at byte address n holds n.
  assign imem_data = imem_addr;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  logic        w_rst_n;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_cnt;
  logic        w_valid, w_mis;

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .imem_addr(w_addr), .imem_data(w_addr),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .id_ready(1'b1), .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc),
    .id_pc_plus4(w_pc4), .misalign_err(w_mis), .fetch_count(w_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        hl;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic hl,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ea, input logic em, input logic [31:0] ec);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.hl = hl; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_addr = ea; v.e_mis = em; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[21];

  // Reference model: architectural view of the stage, updated once per rising edge.
  int          m_mode;   // 0 = boot, 1 = run, 2 = halted
  logic [31:0] m_pc, m_ipc, m_cnt;
  bit          m_valid, m_mis;

  task automatic model_step();
    bit take;
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_ipc = 0; m_cnt = 0; m_valid = 0; m_mis = 0;
      return;
    end
    m_mis = redirect_valid && (redirect_pc % 4 != 0);
    if (redirect_valid) begin
      m_pc    = redirect_pc - redirect_pc % 4;
      m_valid = 0;
      m_mode  = 1;
    end else begin
      take = (m_mode == 1) && !halt && (!m_valid || id_ready);
      if (take) begin
        m_ipc   = m_pc;
        m_pc    = m_pc + 4;
        m_valid = 1;
        m_cnt   = m_cnt + 1;
      end else if (id_ready) begin
        m_valid = 0;
      end
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && halt) m_mode = 2;
    end
  endtask

  initial begin
    rst_n = 0; w_rst_n = 0; redirect_valid = 0; redirect_pc = 0; halt = 0; id_ready = 1;

    // Power-on then bring-up, stall, redirect, misalign, halt sequence.
    tbl[0]  = mk(0, 32'h0,   0, 1, 0, 32'h0,   32'h0,   0, 0);
    tbl[1]  = mk(0, 32'h0,   0, 1, 1, 32'h0,   32'h4,   0, 1);
    tbl[2]  = mk(0, 32'h0,   0, 1, 1, 32'h4,   32'h8,   0, 2);
    tbl[3]  = mk(0, 32'h0,   0, 1, 1, 32'h8,   32'hC,   0, 3);
    tbl[4]  = mk(0, 32'h0,   0, 0, 1, 32'h8,   32'hC,   0, 3);
    tbl[5]  = mk(0, 32'h0,   0, 0, 1, 32'h8,   32'hC,   0, 3);
    tbl[6]  = mk(0, 32'h0,   0, 0, 1, 32'h8,   32'hC,   0, 3);
    tbl[7]  = mk(0, 32'h0,   0, 1, 1, 32'hC,   32'h10,  0, 4);
    tbl[8]  = mk(1, 32'h40,  0, 0, 0, 32'h0,   32'h40,  0, 4);
    tbl[9]  = mk(0, 32'h0,   0, 1, 1, 32'h40,  32'h44,  0, 5);
    tbl[10] = mk(1, 32'h43,  0, 1, 0, 32'h0,   32'h40,  1, 5);
    tbl[11] = mk(0, 32'h0,   0, 1, 1, 32'h40,  32'h44,  0, 6);
    tbl[12] = mk(0, 32'h0,   1, 1, 0, 32'h0,   32'h44,  0, 6);
    tbl[13] = mk(0, 32'h0,   1, 1, 0, 32'h0,   32'h44,  0, 6);
    tbl[14] = mk(0, 32'h0,   0, 1, 0, 32'h0,   32'h44,  0, 6);
    tbl[15] = mk(1, 32'h100, 1, 1, 0, 32'h0,   32'h100, 0, 6);
    tbl[16] = mk(0, 32'h0,   0, 1, 1, 32'h100, 32'h104, 0, 7);
    tbl[17] = mk(1, 32'h200, 1, 1, 0, 32'h0,   32'h200, 0, 7);
    tbl[18] = mk(0, 32'h0,   0, 1, 1, 32'h200, 32'h204, 0, 8);
    tbl[19] = mk(0, 32'h0,   1, 0, 1, 32'h200, 32'h204, 0, 8);
    tbl[20] = mk(0, 32'h0,   0, 1, 0, 32'h0,   32'h204, 0, 8);

    repeat (2) tick();
    chk("reset_valid", 32'(id_valid), 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_instr", id_instr, 32'h0);
    chk("reset_pc", id_pc, 32'h0);
    chk("reset_pc4", id_pc_plus4, 32'h0);
    chk("reset_mis", 32'(misalign_err), 32'h0);
    chk("reset_cnt", fetch_count, 32'h0);

    rst_n = 1;
    for (int i = 0; i < 21; i++) begin
      redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      halt = tbl[i].hl; id_ready = tbl[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_mis", i), 32'(misalign_err), 32'(tbl[i].e_mis));
      chk($sformatf("v%0d_cnt", i), fetch_count, tbl[i].e_cnt);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), id_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_instr", i), id_instr, tbl[i].e_pc);
        chk($sformatf("v%0d_pc4", i), id_pc_plus4, tbl[i].e_pc + 32'd4);
      end
    end

    // Reset during a stall discards held contents and beats redirect/halt.
    redirect_valid = 1; redirect_pc = 32'h300; halt = 0; id_ready = 0;
    tick();
    redirect_valid = 0;
    tick();
    tick();
    chk("stall_valid", 32'(id_valid), 32'h1);
    chk("stall_pc", id_pc, 32'h300);
    rst_n = 0; redirect_valid = 1; redirect_pc = 32'h303; halt = 1;
    tick();
    chk("rst_stall_valid", 32'(id_valid), 32'h0);
    chk("rst_stall_pc", id_pc, 32'h0);
    chk("rst_stall_instr", id_instr, 32'h0);
    chk("rst_stall_addr", imem_addr, 32'h0);
    chk("rst_stall_mis", 32'(misalign_err), 32'h0);
    chk("rst_stall_cnt", fetch_count, 32'h0);

    // Randomized run against the reference model.
    redirect_valid = 0; halt = 0;
    model_step();
    for (int n = 0; n < 600; n++) begin
      rst_n          = ($urandom_range(63) != 0);
      redirect_valid = ($urandom_range(7) == 0);
      redirect_pc    = $urandom_range(32'h3FF);
      halt           = ($urandom_range(9) == 0);
      id_ready       = ($urandom_range(1) == 1);
      model_step();
      tick();
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_valid", 32'(id_valid), 32'(m_valid));
      chk("rnd_mis", 32'(misalign_err), 32'(m_mis));
      chk("rnd_cnt", fetch_count, m_cnt);
      if (m_valid) begin
        chk("rnd_pc", id_pc, m_ipc);
        chk("rnd_instr", id_instr, m_ipc);
        chk("rnd_pc4", id_pc_plus4, m_ipc + 32'd4);
      end
    end

    // PC wrap from a top-of-memory reset vector.
    w_rst_n = 1;
    tick();
    chk("wrap_boot_valid", 32'(w_valid), 32'h0);
    chk("wrap_boot_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_valid", 32'(w_valid), 32'h1);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, 32'hFFFF_FFFC);
    chk("wrap_addr", w_addr, 32'h0);
    tick();
    chk("wrap_next_pc", w_pc, 32'h0);
    chk("wrap_next_pc4", w_pc4, 32'h4);
    chk("wrap_cnt", w_cnt, 32'h2);
    chk("wrap_mis", 32'(w_mis), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter IMEM_ADDR_WIDTH, default 32: width of PC and of the instruction-memory address.
REQ-002 Parameter IMEM_DATA_WIDTH, default 32: width of one fetched instruction word.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 imem_addr  output  IMEM_ADDR_WIDTH  byte address to instruction memory, equal to the current PC.
REQ-008 imem_data  input  IMEM_DATA_WIDTH  instruction word; memory read is combinational and same-cycle.
REQ-009 redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-010 redirect_pc  input  IMEM_ADDR_WIDTH  redirect target byte address.
REQ-011 halt  input  1  request to stop fetching.
REQ-012 id_ready  input  1  decode stage accepts id_* this cycle.
REQ-013 id_valid  output  1  id_instr, id_pc and id_pc_plus4 are valid.
REQ-014 id_instr  output  IMEM_DATA_WIDTH  registered instruction.
REQ-015 id_pc  output  IMEM_ADDR_WIDTH  address id_instr was fetched from.
REQ-016 id_pc_plus4  output  IMEM_ADDR_WIDTH  id_pc + 4, modulo 2^IMEM_ADDR_WIDTH.
REQ-017 misalign_err  output  1  one-cycle pulse: the redirect target had nonzero bits [1:0].
REQ-018 fetch_count  output  32  number of instructions captured into id_* since reset.

Function
REQ-019 imem_addr SHALL be driven combinationally from the PC register.
REQ-020 The FSM SHALL have three states, BOOT, RUN and HALTED, and SHALL enter BOOT on reset.
REQ-021 BOOT SHALL last exactly one cycle with no capture, then go to RUN; a redirect in BOOT SHALL still load the PC.
REQ-022 "Advance" SHALL mean: state RUN, redirect_valid=0, and (id_valid=0 or id_ready=1).
REQ-023 On advance at a rising edge, the block SHALL load id_instr<=imem_data, id_pc<=PC, id_pc_plus4<=PC+4, id_valid<=1, PC<=PC+4, and fetch_count+=1; fetch-to-id latency SHALL be 1 cycle.
REQ-024 Stall: when id_valid=1 and id_ready=0, PC and all id_* SHALL hold.
REQ-025 When id_valid=1, id_ready=1 and there is no advance (HALTED or BOOT), id_valid SHALL go to 0.
REQ-026 Redirect SHALL have top priority in any state: PC<={redirect_pc[31:2],2'b00}, id_valid<=0 (flush, no capture), regardless of id_ready.
REQ-027 If redirect_pc[1:0]!=0 at a redirect, misalign_err SHALL be 1 for exactly the next cycle; otherwise misalign_err SHALL be 0.
REQ-028 RUN->HALTED SHALL occur on halt=1 with redirect_valid=0; that cycle SHALL NOT capture.
REQ-029 HALTED->RUN SHALL occur only on redirect_valid=1; halt=1 in HALTED SHALL have no further effect.
REQ-030 Simultaneous halt and redirect in RUN SHALL perform the redirect and stay in RUN.
REQ-031 PC+4 SHALL wrap: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-032 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0; it SHALL NOT increment on stall, flush or halt.

Reset
REQ-033 With rst_n=0 at a rising edge: PC<=RESET_PC, state<=BOOT, id_valid<=0, id_instr<=0, id_pc<=0, id_pc_plus4<=0, misalign_err<=0, fetch_count<=0.
REQ-034 Reset SHALL override redirect, halt and stall; reset mid-stall SHALL discard the held id_* contents.
REQ-035 Outputs SHALL NOT change between clock edges except imem_addr, which follows the PC.

Verification
REQ-036 Release reset, id_ready=1, memory word at address n = n -> first id_valid 2 cycles after release, with id_pc=0 and id_instr=0; then id_pc 4, 8, 12 on successive cycles; fetch_count=3 after the third capture.
REQ-037 id_ready=0 for 3 cycles while id_pc=8 -> id_* hold at pc 8; imem_addr holds at 12; next capture after id_ready=1 has id_pc=12.
REQ-038 redirect_valid=1, redirect_pc=32'h40, with id_ready=0 and id_valid=1 -> next cycle id_valid=0 and imem_addr=32'h40; the following cycle id_pc=32'h40.
REQ-039 redirect_pc=32'h43 -> imem_addr=32'h40 and a misalign_err pulse 1 cycle wide.
REQ-040 halt=1 in RUN -> no further captures and fetch_count frozen; a later redirect to 32'h100 -> RUN, with next id_pc=32'h100.
REQ-041 RESET_PC=32'hFFFF_FFFC -> first id_pc=32'hFFFF_FFFC with id_pc_plus4=0; next id_pc=0.
